// File: rtl/pc_redirect_unit.sv
// Fetch-PC owner for the 5-stage MIPS pipeline: picks the next PC from
// EX branches, ID jumps, stalls or sequential flow, and raises flushes.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             id_valid,
   input  logic [1:0]       id_PCSrc,
   input  logic [31:0]      id_pc_plus4,
   input  logic [25:0]      id_jidx,
   input  logic [31:0]      id_rs_data,
   input  logic             ex_valid,
   input  logic [1:0]       ex_PCSrc,
   input  logic [2:0]       ex_BranchOp,
   input  logic [31:0]      ex_rs_data,
   input  logic [31:0]      ex_rt_data,
   input  logic [31:0]      ex_pc_plus4,
   input  logic [31:0]      ex_imm_ext,
   output logic [31:0]      pc,
   output logic             if_valid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic [CNT_W-1:0] redirect_cnt
);

   typedef enum logic {StBoot, StRun} state_e;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        run;
   logic        br_cond;
   logic        br_take;
   logic        jmp_take;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic        unused_bits;

   // Only the bits that form a target are consumed; the rest are folded here.
   assign unused_bits = ^{id_pc_plus4[27:0], id_rs_data[1:0], ex_imm_ext[31:30]};

   always_comb begin
      br_cond = 1'b0;
      case (ex_BranchOp)
         3'd0:    br_cond = (ex_rs_data == ex_rt_data);
         3'd1:    br_cond = (ex_rs_data != ex_rt_data);
         3'd2:    br_cond = ($signed(ex_rs_data) <= 32'sd0);
         3'd3:    br_cond = ($signed(ex_rs_data) >  32'sd0);
         3'd4:    br_cond = ($signed(ex_rs_data) <  32'sd0);
         default: br_cond = 1'b0;
      endcase
   end

   // Reset high suppresses every decision so flushes read 0 during reset.
   assign run        = (state_q == StRun) && !reset;
   assign br_take    = run && ex_valid && (ex_PCSrc == 2'b01) && br_cond;
   assign jmp_take   = run && id_valid && id_PCSrc[1] && !stall;
   assign br_target  = ex_pc_plus4 + {ex_imm_ext[29:0], 2'b00};
   assign jmp_target = id_PCSrc[0] ? {id_rs_data[31:2], 2'b00}
                                   : {id_pc_plus4[31:28], id_jidx, 2'b00};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (br_take) begin
               pc_d       = br_target;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end else if (jmp_take) begin
               pc_d       = jmp_target;
               flush_ifid = 1'b1;
            end else if (!stall) begin
               pc_d = pc_q + 32'd4;
            end
            if (br_take || jmp_take) begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc           = pc_q;
   assign if_valid     = (state_q == StRun);
   assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: expectations queued at drive time,
// observations queued #1 after each negedge drive, compared per scenario.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        id_valid;
   logic [1:0]  id_PCSrc;
   logic [31:0] id_pc_plus4;
   logic [25:0] id_jidx;
   logic [31:0] id_rs_data;
   logic        ex_valid;
   logic [1:0]  ex_PCSrc;
   logic [2:0]  ex_BranchOp;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_pc_plus4;
   logic [31:0] ex_imm_ext;
   logic [31:0] pc;
   logic        if_valid;
   logic        flush_ifid;
   logic        flush_idex;
   logic [15:0] redirect_cnt;

   typedef struct packed {
      logic [31:0] pc;
      logic        iv;
      logic        fi;
      logic        fe;
      logic [15:0] cnt;
   } obs_t;

   obs_t  exp_q[$];
   obs_t  obs_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   pc_redirect_unit #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .id_valid     (id_valid),
      .id_PCSrc     (id_PCSrc),
      .id_pc_plus4  (id_pc_plus4),
      .id_jidx      (id_jidx),
      .id_rs_data   (id_rs_data),
      .ex_valid     (ex_valid),
      .ex_PCSrc     (ex_PCSrc),
      .ex_BranchOp  (ex_BranchOp),
      .ex_rs_data   (ex_rs_data),
      .ex_rt_data   (ex_rt_data),
      .ex_pc_plus4  (ex_pc_plus4),
      .ex_imm_ext   (ex_imm_ext),
      .pc           (pc),
      .if_valid     (if_valid),
      .flush_ifid   (flush_ifid),
      .flush_idex   (flush_idex),
      .redirect_cnt (redirect_cnt)
   );

   task automatic clear_in();
      stall = 1'b0; id_valid = 1'b0; id_PCSrc = 2'b00; id_pc_plus4 = '0;
      id_jidx = '0; id_rs_data = '0; ex_valid = 1'b0; ex_PCSrc = 2'b00;
      ex_BranchOp = 3'd0; ex_rs_data = '0; ex_rt_data = '0;
      ex_pc_plus4 = '0; ex_imm_ext = '0;
   endtask

   task automatic set_br(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc4, input logic [31:0] imm);
      ex_valid = 1'b1; ex_PCSrc = 2'b01; ex_BranchOp = op;
      ex_rs_data = rs; ex_rt_data = rt; ex_pc_plus4 = pc4; ex_imm_ext = imm;
   endtask

   task automatic set_jmp(input logic [1:0] src, input logic [31:0] pc4,
                          input logic [25:0] jidx, input logic [31:0] rs);
      id_valid = 1'b1; id_PCSrc = src; id_pc_plus4 = pc4; id_jidx = jidx; id_rs_data = rs;
   endtask

   // Inputs are already driven at the negedge; queue expectation, sample, move on.
   task automatic tick(input string n, input logic [31:0] p, input logic v, input logic fi,
                       input logic fe, input logic [15:0] c);
      exp_q.push_back({p, v, fi, fe, c});
      name_q.push_back(n);
      #1;
      obs_q.push_back({pc, if_valid, flush_ifid, flush_idex, redirect_cnt});
      @(negedge clk);
   endtask

   task automatic test_reset();
      obs_t e, o; string nm;
      reset = 1'b1; set_br(3'd0, 32'd5, 32'd5, 32'h100, 32'hFFFF_FFFE);
      tick("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
      tick("boot_ignores_br", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      clear_in();
      tick("run_pc0", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick("run_pc4", 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);
      tick("run_pc8", 32'h8, 1'b1, 1'b0, 1'b0, 16'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_branch_eq();
      obs_t e, o; string nm;
      set_br(3'd0, 32'd5, 32'd5, 32'h100, 32'hFFFF_FFFE);
      tick("beq_take", 32'hC, 1'b1, 1'b1, 1'b1, 16'd0);
      clear_in();
      tick("beq_target", 32'hF8, 1'b1, 1'b0, 1'b0, 16'd1);
      set_br(3'd1, 32'd7, 32'd7, 32'h300, 32'h4);
      tick("bne_equal_nt", 32'hFC, 1'b1, 1'b0, 1'b0, 16'd1);
      set_br(3'd1, 32'd1, 32'd2, 32'h400, 32'h10);
      tick("bne_take", 32'h100, 1'b1, 1'b1, 1'b1, 16'd1);
      set_br(3'd0, 32'd9, 32'd9, 32'h700, 32'h4); ex_PCSrc = 2'b00;
      tick("ex_src00_nt", 32'h440, 1'b1, 1'b0, 1'b0, 16'd2);
      set_br(3'd0, 32'd9, 32'd9, 32'h700, 32'h4); ex_valid = 1'b0;
      tick("ex_invalid_nt", 32'h444, 1'b1, 1'b0, 1'b0, 16'd2);
      set_br(3'd5, 32'd9, 32'd9, 32'h700, 32'h4);
      tick("op5_never", 32'h448, 1'b1, 1'b0, 1'b0, 16'd2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_branch_signed();
      obs_t e, o; string nm;
      set_br(3'd2, 32'h8000_0000, 32'h0, 32'h2000, 32'h4);
      tick("blez_neg_take", 32'h44C, 1'b1, 1'b1, 1'b1, 16'd2);
      set_br(3'd3, 32'h0, 32'h0, 32'h9000, 32'h4);
      tick("bgtz_zero_nt", 32'h2010, 1'b1, 1'b0, 1'b0, 16'd3);
      set_br(3'd2, 32'h0, 32'h0, 32'h3000, 32'h0);
      tick("blez_zero_take", 32'h2014, 1'b1, 1'b1, 1'b1, 16'd3);
      set_br(3'd4, 32'h0, 32'h0, 32'h9000, 32'h4);
      tick("bltz_zero_nt", 32'h3000, 1'b1, 1'b0, 1'b0, 16'd4);
      set_br(3'd3, 32'h7FFF_FFFF, 32'h0, 32'h5000, 32'h1);
      tick("bgtz_max_take", 32'h3004, 1'b1, 1'b1, 1'b1, 16'd4);
      set_br(3'd4, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF0, 32'h8);
      tick("bltz_wrap_take", 32'h5004, 1'b1, 1'b1, 1'b1, 16'd5);
      clear_in();
      tick("wrap_target", 32'h10, 1'b1, 1'b0, 1'b0, 16'd6);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_jump();
      obs_t e, o; string nm;
      set_jmp(2'b10, 32'h1000_0010, 26'h40, 32'h0);
      tick("j_take", 32'h14, 1'b1, 1'b1, 1'b0, 16'd6);
      clear_in(); set_jmp(2'b01, 32'h1000_0010, 26'h40, 32'h0);
      tick("id_src01_nt", 32'h1000_0100, 1'b1, 1'b0, 1'b0, 16'd7);
      clear_in(); set_jmp(2'b10, 32'h1000_0010, 26'h40, 32'h0); id_valid = 1'b0;
      tick("id_invalid_nt", 32'h1000_0104, 1'b1, 1'b0, 1'b0, 16'd7);
      clear_in(); set_jmp(2'b11, 32'h0, 26'h0, 32'hABCD_EF07);
      tick("jalr_take", 32'h1000_0108, 1'b1, 1'b1, 1'b0, 16'd7);
      clear_in();
      tick("jalr_target", 32'hABCD_EF04, 1'b1, 1'b0, 1'b0, 16'd8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_jr_stall();
      obs_t e, o; string nm;
      set_jmp(2'b11, 32'h0, 26'h0, 32'h203); stall = 1'b1;
      tick("jr_stall0", 32'hABCD_EF08, 1'b1, 1'b0, 1'b0, 16'd8);
      tick("jr_stall1", 32'hABCD_EF08, 1'b1, 1'b0, 1'b0, 16'd8);
      stall = 1'b0;
      tick("jr_release", 32'hABCD_EF08, 1'b1, 1'b1, 1'b0, 16'd8);
      clear_in();
      tick("jr_target", 32'h200, 1'b1, 1'b0, 1'b0, 16'd9);
      stall = 1'b1;
      tick("stall_hold", 32'h204, 1'b1, 1'b0, 1'b0, 16'd9);
      stall = 1'b0;
      tick("stall_done", 32'h204, 1'b1, 1'b0, 1'b0, 16'd9);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o; string nm;
      set_br(3'd0, 32'd1, 32'd1, 32'h800, 32'h40);
      set_jmp(2'b11, 32'h0, 26'h0, 32'h600); stall = 1'b1;
      tick("br_over_jr_stall", 32'h208, 1'b1, 1'b1, 1'b1, 16'd9);
      clear_in();
      set_br(3'd0, 32'd3, 32'd3, 32'h1000, 32'h0);
      set_jmp(2'b10, 32'h1000_0010, 26'h40, 32'h0);
      tick("br_and_j_once", 32'h900, 1'b1, 1'b1, 1'b1, 16'd10);
      clear_in(); set_jmp(2'b10, 32'h1000_0010, 26'h40, 32'h0);
      tick("j_back_to_back", 32'h1000, 1'b1, 1'b1, 1'b0, 16'd11);
      clear_in();
      tick("after_b2b", 32'h1000_0100, 1'b1, 1'b0, 1'b0, 16'd12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   task automatic test_reset_in_run();
      obs_t e, o; string nm;
      reset = 1'b1; set_br(3'd0, 32'd1, 32'd1, 32'h800, 32'h40);
      tick("rst_inflight", 32'h1000_0104, 1'b1, 1'b0, 1'b0, 16'd12);
      reset = 1'b0; clear_in();
      tick("rst_boot", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      tick("rst_run0", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick("rst_run4", 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h v=%b fi=%b fe=%b cnt=%0d, want pc=%h v=%b fi=%b fe=%b cnt=%0d",
                     nm, o.pc, o.iv, o.fi, o.fe, o.cnt, e.pc, e.iv, e.fi, e.fe, e.cnt);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_in();
      @(negedge clk);
      test_reset();
      test_branch_eq();
      test_branch_signed();
      test_jump();
      test_jr_stall();
      test_back_to_back();
      test_reset_in_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
